// File: rtl/ps2_defs.sv
//==============================================================================
// Module : ps2_defs
// Brief  : Shared PS/2 mouse command/response codes and host sequencer encodings.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_defs;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] DEV_ID_MOUSE = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SEND_RST = 4'd1,
        ST_ACK_RST  = 4'd2,
        ST_BAT      = 4'd3,
        ST_DEV_ID   = 4'd4,
        ST_SEND_EN  = 4'd5,
        ST_ACK_EN   = 4'd6,
        ST_STREAM   = 4'd7,
        ST_ERR      = 4'd8
    } state_t;

    // Handshake with the serial sender inside the SEND_* states.
    typedef enum logic [1:0] {
        PH_REQ  = 2'd0,
        PH_RISE = 2'd1,
        PH_FALL = 2'd2
    } tx_phase_t;

endpackage

`default_nettype wire

// File: rtl/ps2_frame_decode.sv
//==============================================================================
// Module : ps2_frame_decode
// Brief  : Combinational 11-bit PS/2 frame check/unpack and 10-bit tx word build.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_frame_decode (
    input  logic [10:0] i_rx_word,
    input  logic [7:0]  i_tx_byte,
    output logic [7:0]  o_rx_byte,
    output logic        o_rx_ok,
    output logic [9:0]  o_tx_bits
);

    // Data travels LSB first, so d0 sits at the high index of the frame.
    always_comb begin
        o_rx_byte = '0;
        o_tx_bits = '0;
        for (int i = 0; i < 8; i++) begin
            o_rx_byte[i]     = i_rx_word[9 - i];
            o_tx_bits[9 - i] = i_tx_byte[i];
        end
        o_tx_bits[1] = ~^i_tx_byte;
        o_tx_bits[0] = 1'b1;
    end

    assign o_rx_ok = ~i_rx_word[10] & i_rx_word[0] & (^i_rx_word[9:1]);

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_host_ctrl.sv
//==============================================================================
// Module : ps2_mouse_host_ctrl
// Brief  : PS/2 mouse host sequencer: reset/enable init with retries, then
//          3-byte stream packet assembly.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_mouse_host_ctrl
    import ps2_defs::*;
#(
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int BAT_TIMEOUT = 100_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_word_ready,
    input  logic [10:0] rx_word,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [9:0]  tx_word,
    output logic        ready,
    output logic        error,
    output logic        frame_err,
    output logic        pkt_valid,
    output logic [23:0] pkt
);

    localparam logic [26:0] c_ACK_LIM   = 27'(ACK_TIMEOUT - 1);
    localparam logic [26:0] c_BAT_LIM   = 27'(BAT_TIMEOUT - 1);
    localparam logic [26:0] c_TIMER_MAX = '1;
    localparam logic [2:0]  c_MAX_RETRY = 3'(MAX_RETRY);

    state_t      r_state, w_state_nxt;
    tx_phase_t   r_phase, w_phase_nxt;
    logic [26:0] r_timer, w_timer_nxt;
    logic [1:0]  r_retry, w_retry_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_b0, w_b0_nxt;
    logic [7:0]  r_b1, w_b1_nxt;
    logic        r_rdy_d, r_rx_evt;
    logic [10:0] r_rx_word;
    logic        r_tx_send, w_tx_send_nxt;
    logic [9:0]  r_tx_word, w_tx_word_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_error, w_error_nxt;
    logic        r_frame_err, w_frame_err_nxt;
    logic        r_pkt_valid, w_pkt_valid_nxt;
    logic [23:0] r_pkt, w_pkt_nxt;

    logic [7:0]  w_rx_byte;
    logic        w_rx_ok, w_rx_good, w_rx_bad;
    logic [7:0]  w_cmd;
    logic [9:0]  w_tx_bits;
    logic        w_ack_to, w_bat_to, w_retry_ok;

    assign w_cmd = (r_state == ST_SEND_EN) ? CMD_ENABLE : CMD_RESET;

    ps2_frame_decode u_decode (
        .i_rx_word (r_rx_word),
        .i_tx_byte (w_cmd),
        .o_rx_byte (w_rx_byte),
        .o_rx_ok   (w_rx_ok),
        .o_tx_bits (w_tx_bits)
    );

    assign w_rx_good  = r_rx_evt & w_rx_ok;
    assign w_rx_bad   = r_rx_evt & ~w_rx_ok;
    assign w_ack_to   = (r_timer >= c_ACK_LIM);
    assign w_bat_to   = (r_timer >= c_BAT_LIM);
    assign w_retry_ok = (({1'b0, r_retry} + 3'd1) < c_MAX_RETRY);

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_retry_nxt     = r_retry;
        w_idx_nxt       = r_idx;
        w_b0_nxt        = r_b0;
        w_b1_nxt        = r_b1;
        w_tx_send_nxt   = 1'b0;
        w_tx_word_nxt   = r_tx_word;
        w_ready_nxt     = r_ready;
        w_error_nxt     = r_error;
        w_frame_err_nxt = 1'b0;
        w_pkt_valid_nxt = 1'b0;
        w_pkt_nxt       = r_pkt;

        // A start pulse overrides everything, including a byte arriving this cycle.
        if (start) begin
            w_state_nxt = ST_SEND_RST;
            w_phase_nxt = PH_REQ;
            w_retry_nxt = '0;
            w_idx_nxt   = '0;
            w_ready_nxt = 1'b0;
            w_error_nxt = 1'b0;
        end else begin
            w_frame_err_nxt = w_rx_bad;
            case (r_state)
                ST_IDLE, ST_ERR: ;
                ST_SEND_RST, ST_SEND_EN: begin
                    case (r_phase)
                        PH_REQ: begin
                            if (!tx_busy) begin
                                w_tx_send_nxt = 1'b1;
                                w_tx_word_nxt = w_tx_bits;
                                w_phase_nxt   = PH_RISE;
                            end
                        end
                        PH_RISE: if (tx_busy) w_phase_nxt = PH_FALL;
                        PH_FALL: begin
                            if (!tx_busy)
                                w_state_nxt = (r_state == ST_SEND_RST) ? ST_ACK_RST : ST_ACK_EN;
                        end
                        default: w_phase_nxt = PH_REQ;
                    endcase
                end
                ST_ACK_RST, ST_ACK_EN: begin
                    if (w_rx_good && w_rx_byte == RSP_ACK) begin
                        if (r_state == ST_ACK_RST) begin
                            w_state_nxt = ST_BAT;
                        end else begin
                            w_state_nxt = ST_STREAM;
                            w_ready_nxt = 1'b1;
                        end
                    end else if ((w_rx_good && (w_rx_byte == RSP_RESEND || w_rx_byte != RSP_ACK))
                                 || w_ack_to) begin
                        w_retry_nxt = r_retry + 2'd1;
                        if (w_retry_ok)
                            w_state_nxt = (r_state == ST_ACK_RST) ? ST_SEND_RST : ST_SEND_EN;
                        else
                            w_state_nxt = ST_ERR;
                    end
                end
                ST_BAT: begin
                    if (w_rx_good && w_rx_byte == RSP_BAT_OK)
                        w_state_nxt = ST_DEV_ID;
                    else if ((w_rx_good && w_rx_byte == RSP_BAT_FAIL) || w_bat_to)
                        w_state_nxt = ST_ERR;
                end
                ST_DEV_ID: begin
                    if (w_rx_good && w_rx_byte == DEV_ID_MOUSE) begin
                        w_state_nxt = ST_SEND_EN;
                        w_retry_nxt = '0;
                    end else if (w_bat_to) begin
                        w_state_nxt = ST_ERR;
                    end
                end
                ST_STREAM: begin
                    if (w_rx_bad) begin
                        w_idx_nxt = '0;
                    end else if (w_rx_good) begin
                        case (r_idx)
                            2'd0: begin
                                // Bit 3 is always set in a first byte; anything else is a resync.
                                if (w_rx_byte[3]) begin
                                    w_b0_nxt  = w_rx_byte;
                                    w_idx_nxt = 2'd1;
                                end
                            end
                            2'd1: begin
                                w_b1_nxt  = w_rx_byte;
                                w_idx_nxt = 2'd2;
                            end
                            default: begin
                                w_pkt_nxt       = {r_b0, r_b1, w_rx_byte};
                                w_pkt_valid_nxt = 1'b1;
                                w_idx_nxt       = 2'd0;
                            end
                        endcase
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_state_nxt != r_state)
            w_phase_nxt = PH_REQ;
        if (w_state_nxt == ST_ERR)
            w_error_nxt = 1'b1;

        if (start || (w_state_nxt != r_state))
            w_timer_nxt = '0;
        else if (r_timer == c_TIMER_MAX)
            w_timer_nxt = r_timer;
        else
            w_timer_nxt = r_timer + 27'd1;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_REQ;
            r_timer     <= '0;
            r_retry     <= '0;
            r_idx       <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_rdy_d     <= 1'b0;
            r_rx_evt    <= 1'b0;
            r_rx_word   <= '0;
            r_tx_send   <= 1'b0;
            r_tx_word   <= '0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_frame_err <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pkt       <= '0;
        end else begin
            r_rdy_d  <= rx_word_ready;
            r_rx_evt <= rx_word_ready & ~r_rdy_d;
            if (rx_word_ready && !r_rdy_d)
                r_rx_word <= rx_word;
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_timer     <= w_timer_nxt;
            r_retry     <= w_retry_nxt;
            r_idx       <= w_idx_nxt;
            r_b0        <= w_b0_nxt;
            r_b1        <= w_b1_nxt;
            r_tx_send   <= w_tx_send_nxt;
            r_tx_word   <= w_tx_word_nxt;
            r_ready     <= w_ready_nxt;
            r_error     <= w_error_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_pkt       <= w_pkt_nxt;
        end
    end

    assign tx_send   = r_tx_send;
    assign tx_word   = r_tx_word;
    assign ready     = r_ready;
    assign error     = r_error;
    assign frame_err = r_frame_err;
    assign pkt_valid = r_pkt_valid;
    assign pkt       = r_pkt;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_host_ctrl.sv
//==============================================================================
// Module : tb_ps2_mouse_host_ctrl
// Brief  : Self-checking bench for the PS/2 mouse host sequencer.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ps2_mouse_host_ctrl;

    localparam int ACK_TO    = 100;
    localparam int BAT_TO    = 400;
    localparam int RETRIES   = 3;
    localparam int BUSY_CYCS = 6;

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_word_ready = 1'b0;
    logic [10:0] rx_word = '0;
    logic        tx_busy = 1'b0;
    logic        tx_send, ready, error, frame_err, pkt_valid;
    logic [9:0]  tx_word;
    logic [23:0] pkt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_send = 0;
    int fall_cyc = 0;
    int fe_cnt = 0;

    typedef struct { logic [9:0] w; int c; } txrec_t;
    txrec_t      tx_log[$];
    logic [23:0] got_q[$];

    typedef struct {
        logic [7:0]  b;
        bit          good;
        bit          exp_pv;
        logic [23:0] exp_pkt;
        bit          exp_fe;
    } vec_t;

    logic        s_pv, s_fe, s_rdy;
    logic [23:0] s_pkt;

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    ps2_mouse_host_ctrl #(
        .ACK_TIMEOUT (ACK_TO),
        .BAT_TIMEOUT (BAT_TO),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .ck            (ck),
        .reset         (reset),
        .start         (start),
        .rx_word_ready (rx_word_ready),
        .rx_word       (rx_word),
        .tx_busy       (tx_busy),
        .tx_send       (tx_send),
        .tx_word       (tx_word),
        .ready         (ready),
        .error         (error),
        .frame_err     (frame_err),
        .pkt_valid     (pkt_valid),
        .pkt           (pkt)
    );

    // Sender model: accept a request, go busy for a while, then drop busy.
    initial begin : sender
        forever begin
            @(posedge ck);
            if (tx_send === 1'b1 && reset === 1'b0) begin
                tx_log.push_back('{w: tx_word, c: cyc});
                n_send = n_send + 1;
                #1 tx_busy = 1'b1;
                repeat (BUSY_CYCS) @(posedge ck);
                #1 tx_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    always @(posedge ck) begin
        if (pkt_valid === 1'b1) got_q.push_back(pkt);
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    function automatic logic [9:0] frame10(input logic [7:0] b);
        return {rev8(b), ~^b, 1'b1};
    endfunction

    function automatic logic [10:0] frame11(input logic [7:0] b, input bit good);
        return {1'b0, rev8(b), (good ? ~^b : ^b), 1'b1};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pulse_start();
        tx_log.delete();
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit good);
        rx_word       = frame11(b, good);
        rx_word_ready = 1'b1;
        @(posedge ck);
        @(posedge ck);
        @(negedge ck);
        s_pv  = pkt_valid;
        s_fe  = frame_err;
        s_pkt = pkt;
        s_rdy = ready;
        rx_word_ready = 1'b0;
        @(negedge ck);
    endtask

    task automatic wait_tx(input logic [7:0] b, input string nm, output int scyc);
        int     n;
        txrec_t r;
        n    = 0;
        scyc = 0;
        while (tx_log.size() == 0 && n < 1000) begin
            @(negedge ck);
            n++;
        end
        if (tx_log.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no tx_send within 1000 cycles", nm);
        end else begin
            r    = tx_log.pop_front();
            scyc = r.c;
            chk(nm, 64'(r.w), 64'(frame10(b)));
        end
        n = 0;
        while (tx_busy !== 1'b0 && n < 100) begin
            @(negedge ck);
            n++;
        end
        @(negedge ck);
        @(negedge ck);
    endtask

    task automatic do_init(input string tag);
        int sc;
        pulse_start();
        wait_tx(8'hFF, {tag, " cmd reset"}, sc);
        send_rx(8'hFA, 1'b1);
        send_rx(8'hAA, 1'b1);
        send_rx(8'h00, 1'b1);
        wait_tx(8'hF4, {tag, " cmd enable"}, sc);
        send_rx(8'hFA, 1'b1);
        chk({tag, " ready"}, 64'(s_rdy), 64'd1);
    endtask

    initial begin : main
        vec_t        tbl[$];
        logic [7:0]  part[$];
        logic [23:0] exp_q[$];
        int          n0, sc, s2, f0, gap, fe0, nbad, n;
        logic [7:0]  rb;
        bit          rg;

        tbl = '{
            '{8'h08, 1, 0, 24'h0, 0}, '{8'h05, 1, 0, 24'h0, 0}, '{8'hFB, 1, 1, 24'h0805FB, 0},
            '{8'h00, 1, 0, 24'h0, 0}, '{8'h08, 1, 0, 24'h0, 0}, '{8'h01, 1, 0, 24'h0, 0},
            '{8'h02, 1, 1, 24'h080102, 0},
            '{8'h09, 1, 0, 24'h0, 0}, '{8'h01, 1, 0, 24'h0, 0}, '{8'h02, 0, 0, 24'h0, 1},
            '{8'h09, 1, 0, 24'h0, 0}, '{8'h0A, 1, 0, 24'h0, 0}, '{8'h0B, 1, 1, 24'h090A0B, 0},
            '{8'h22, 0, 0, 24'h0, 1}, '{8'h33, 1, 0, 24'h0, 0}, '{8'h0C, 1, 0, 24'h0, 0},
            '{8'h7F, 1, 0, 24'h0, 0}, '{8'h80, 1, 1, 24'h0C7F80, 0}
        };

        // Reset state
        repeat (3) @(negedge ck);
        chk("reset outputs", {26'd0, tx_send, tx_word, ready, error, frame_err, pkt_valid, pkt}, 64'd0);
        reset = 1'b0;
        @(negedge ck);

        // Nominal init
        n0 = n_send;
        do_init("init");
        chk("init error", 64'(error), 64'd0);
        chk("init send count", 64'(n_send - n0), 64'd2);

        // Stream table
        foreach (tbl[i]) begin
            send_rx(tbl[i].b, tbl[i].good);
            chk($sformatf("tbl%0d pkt_valid", i), 64'(s_pv), 64'(tbl[i].exp_pv));
            chk($sformatf("tbl%0d frame_err", i), 64'(s_fe), 64'(tbl[i].exp_fe));
            if (tbl[i].exp_pv) chk($sformatf("tbl%0d pkt", i), 64'(s_pkt), 64'(tbl[i].exp_pkt));
        end

        // Random stream against a queue-based packet model
        got_q.delete();
        fe0  = fe_cnt;
        nbad = 0;
        for (int k = 0; k < 300; k++) begin
            rb = 8'($urandom_range(0, 255));
            rg = ($urandom_range(0, 9) != 0);
            if (!rg) begin
                nbad++;
                part.delete();
            end else if (part.size() != 0 || rb[3]) begin
                part.push_back(rb);
                if (part.size() == 3) begin
                    exp_q.push_back({part[0], part[1], part[2]});
                    part.delete();
                end
            end
            send_rx(rb, rg);
        end
        chk("rand pkt count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("rand pkt%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
        chk("rand frame_err count", 64'(fe_cnt - fe0), 64'(nbad));

        // Parity error on the reset ack, then timeout-driven resend
        pulse_start();
        chk("restart clears ready", 64'(ready), 64'd0);
        wait_tx(8'hFF, "perr cmd reset", sc);
        f0 = fall_cyc;
        send_rx(8'hFA, 1'b0);
        chk("perr frame_err", 64'(s_fe), 64'd1);
        wait_tx(8'hFF, "perr resend", s2);
        gap = s2 - f0;
        chk("perr timeout gap in range", 64'(gap >= ACK_TO && gap <= ACK_TO + 8), 64'd1);

        // Resend responses exhaust retries
        pulse_start();
        n0 = n_send;
        for (int k = 0; k < 3; k++) begin
            wait_tx(8'hFF, $sformatf("retry%0d cmd", k), sc);
            send_rx(8'hFE, 1'b1);
        end
        repeat (250) @(negedge ck);
        chk("retry send count", 64'(n_send - n0), 64'd3);
        chk("retry error", 64'(error), 64'd1);
        chk("retry ready", 64'(ready), 64'd0);
        pulse_start();
        chk("start clears error", 64'(error), 64'd0);

        // No answer to enable: timeouts and final error
        wait_tx(8'hFF, "to cmd reset", sc);
        send_rx(8'hFA, 1'b1);
        send_rx(8'hAA, 1'b1);
        send_rx(8'h00, 1'b1);
        n0 = n_send;
        for (int k = 0; k < 3; k++) wait_tx(8'hF4, $sformatf("to enable%0d", k), sc);
        n = 0;
        while (error !== 1'b1 && n < 400) begin
            @(negedge ck);
            n++;
        end
        chk("timeout error", 64'(error), 64'd1);
        chk("timeout send count", 64'(n_send - n0), 64'd3);

        // Asynchronous reset mid-stream, then a clean re-init
        do_init("reinit");
        send_rx(8'h08, 1'b1);
        #2 reset = 1'b1;
        @(negedge ck);
        chk("midstream reset outputs",
            {26'd0, tx_send, tx_word, ready, error, frame_err, pkt_valid, pkt}, 64'd0);
        reset = 1'b0;
        @(negedge ck);
        do_init("post-reset");
        send_rx(8'h08, 1'b1);
        send_rx(8'h05, 1'b1);
        send_rx(8'hFB, 1'b1);
        chk("post-reset pkt_valid", 64'(s_pv), 64'd1);
        chk("post-reset pkt", 64'(s_pkt), 64'h0805FB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
